ecc_decode_pipe: RTL and testbench



---
 rtl/ecc_decode_pipe.sv | 133 +++++++++++++
 tb/tb_ecc_decode_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_decode_pipe.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready handshakes.
// Stage 1 registers syndrome and overall parity; stage 2 registers corrected data and error flags.
module ecc_decode_pipe #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 16,
  localparam int ParityWidth = $clog2(DataWidth + $clog2(DataWidth + 1) + 1),
  localparam int CwWidth     = DataWidth + ParityWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CwWidth:0]       in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_data_o,
  output logic                   out_single_err_o,
  output logic                   out_double_err_o,
  output logic [ParityWidth-1:0] out_syndrome_o,
  input  logic                   cnt_clear_i,
  output logic [CntWidth-1:0]    single_cnt_o,
  output logic [CntWidth-1:0]    double_cnt_o
);

  logic                   s1_valid;
  logic [CwWidth-1:0]     s1_cw;
  logic [ParityWidth-1:0] s1_syn;
  logic                   s1_pe;
  logic                   s2_valid;
  logic                   s2_load;
  logic                   out_hs;

  logic [ParityWidth-1:0] in_syn;
  logic                   in_pe;

  logic                   syn_zero;
  logic                   syn_in_range;
  logic                   do_flip;
  logic                   dec_single;
  logic                   dec_double;
  logic [CwWidth-1:0]     cw_fix;
  logic [DataWidth-1:0]   dec_data;

  assign s2_load     = !s2_valid || out_ready_i;
  assign in_ready_o  = !s1_valid || s2_load;
  assign out_valid_o = s2_valid;
  assign out_hs      = s2_valid && out_ready_i;

  // Syndrome bit i covers every Hamming position whose index has bit i set.
  always_comb begin
    in_syn = '0;
    for (int i = 0; i < ParityWidth; i++) begin
      for (int j = 1; j <= CwWidth; j++) begin
        if (((j >> i) & 1) == 1) begin
          in_syn[i] = in_syn[i] ^ in_data_i[j-1];
        end
      end
    end
    in_pe = ^in_data_i;
  end

  always_comb begin
    int idx;
    syn_zero     = (s1_syn == '0);
    syn_in_range = (int'(s1_syn) <= CwWidth);
    do_flip      = s1_pe && !syn_zero && syn_in_range;
    dec_single   = s1_pe && (syn_zero || syn_in_range);
    dec_double   = !syn_zero && !(s1_pe && syn_in_range);
    cw_fix       = s1_cw;
    dec_data     = '0;
    idx          = 0;
    for (int k = 0; k < CwWidth; k++) begin
      if (do_flip && (s1_syn == ParityWidth'(k + 1))) begin
        cw_fix[k] = ~s1_cw[k];
      end
    end
    // Data bits live at the non-power-of-two positions, in ascending order.
    for (int j = 1; j <= CwWidth; j++) begin
      if ((j & (j - 1)) != 0) begin
        dec_data[idx] = cw_fix[j-1];
        idx = idx + 1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_ready_o && in_valid_i) begin
      s1_cw  <= in_data_i[CwWidth-1:0];
      s1_syn <= in_syn;
      s1_pe  <= in_pe;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid         <= 1'b0;
      s2_valid         <= 1'b0;
      out_data_o       <= '0;
      out_single_err_o <= 1'b0;
      out_double_err_o <= 1'b0;
      out_syndrome_o   <= '0;
    end else begin
      if (in_ready_o) begin
        s1_valid <= in_valid_i;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data_o       <= dec_data;
          out_single_err_o <= dec_single;
          out_double_err_o <= dec_double;
          out_syndrome_o   <= s1_syn;
        end
      end
    end
  end

  // Clear takes priority over an increment landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clear_i) begin
      single_cnt_o <= '0;
      double_cnt_o <= '0;
    end else if (out_hs) begin
      if (out_single_err_o && (single_cnt_o != {CntWidth{1'b1}})) begin
        single_cnt_o <= single_cnt_o + CntWidth'(1);
      end
      if (out_double_err_o && (double_cnt_o != {CntWidth{1'b1}})) begin
        double_cnt_o <= double_cnt_o + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Scoreboard bench for ecc_decode_pipe: a default instance plus a CntWidth=2 instance
// sharing the same input stream, so counter saturation can be observed.
module tb_ecc_decode_pipe;

  localparam int DW = 64;
  localparam int PW = 7;
  localparam int CW = 71;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          single;
    logic          dbl;
    logic [PW-1:0] syn;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW:0]   in_data;
  logic          out_ready;
  logic          cnt_clear;

  logic          in_ready, out_valid, out_single, out_double;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_syn;
  logic [15:0]   single_cnt, double_cnt;

  logic          sat_in_ready, sat_out_valid, sat_out_single, sat_out_double;
  logic [DW-1:0] sat_out_data;
  logic [PW-1:0] sat_out_syn;
  logic [1:0]    sat_single_cnt, sat_double_cnt;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;
  int   in_flight = 0;
  int   exp_single = 0, exp_double = 0, exp_sat_single = 0, exp_sat_double = 0;

  ecc_decode_pipe #(.DataWidth(DW), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_single_err_o(out_single), .out_double_err_o(out_double),
    .out_syndrome_o(out_syn), .cnt_clear_i(cnt_clear),
    .single_cnt_o(single_cnt), .double_cnt_o(double_cnt)
  );

  ecc_decode_pipe #(.DataWidth(DW), .CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(sat_in_ready),
    .in_data_i(in_data), .out_valid_o(sat_out_valid), .out_ready_i(out_ready),
    .out_data_o(sat_out_data), .out_single_err_o(sat_out_single), .out_double_err_o(sat_out_double),
    .out_syndrome_o(sat_out_syn), .cnt_clear_i(cnt_clear),
    .single_cnt_o(sat_single_cnt), .double_cnt_o(sat_double_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: data into non-power-of-two positions, then parity bits, then overall parity.
  function automatic logic [CW:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    logic          p;
    int            idx;
    cw  = '0;
    idx = 0;
    for (int j = 1; j <= CW; j++) begin
      if ((j & (j - 1)) != 0) begin
        cw[j-1] = d[idx];
        idx++;
      end
    end
    for (int i = 0; i < PW; i++) begin
      p = 1'b0;
      for (int j = 1; j <= CW; j++) begin
        if (((j >> i) & 1) == 1) p = p ^ cw[j-1];
      end
      cw[(1 << i) - 1] = p;
    end
    return {^cw, cw};
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] d, input logic s, input logic db, input int syn);
    exp_t e;
    e.data   = d;
    e.single = s;
    e.dbl    = db;
    e.syn    = PW'(syn);
    return e;
  endfunction

  function automatic int single_syn(input int b);
    return (b < CW) ? b + 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CW:0] word, input exp_t e);
    int budget;
    bit ok;
    budget   = 200;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = word;
    while (budget > 0 && !ok) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else budget--;
    end
    if (ok) sb.push_back(e);
    else checkOutput("in_handshake_timeout", 128'(ok), 128'(1));
    step();
    in_valid = 1'b0;
    in_data  = 72'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic drain();
    int budget;
    budget = 500;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("drain_timeout", 128'(sb.size() == 0), 128'(1));
    step();
  endtask

  task automatic checkLatency(input string tag);
    @(negedge clk);
    checkOutput({tag, "_cycle1"}, 128'(out_valid), 128'(0));
    @(negedge clk);
    checkOutput({tag, "_cycle2"}, 128'(out_valid), 128'(1));
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: counter model, handshake occupancy model, stall stability and scoreboard pop.
  always @(negedge clk) begin : monitor
    exp_t       e;
    bit         have_e;
    logic [73:0] cur_snap;
    static logic [73:0] prev_snap = '0;
    static bit          prev_stall = 1'b0;
    have_e   = 1'b0;
    cur_snap = {out_valid, out_data, out_single, out_double, out_syn};
    checkOutput("single_cnt", 128'(single_cnt), 128'(exp_single));
    checkOutput("double_cnt", 128'(double_cnt), 128'(exp_double));
    checkOutput("sat_single_cnt", 128'(sat_single_cnt), 128'(exp_sat_single));
    checkOutput("sat_double_cnt", 128'(sat_double_cnt), 128'(exp_sat_double));
    if (!rst) begin
      checkOutput("in_ready", 128'(in_ready), 128'((in_flight < 2) || out_ready));
      if (prev_stall) checkOutput("stall_hold", 128'(cur_snap), 128'(prev_snap));
      if (out_valid && out_ready) begin
        checkOutput("sb_has_entry", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          e      = sb.pop_front();
          have_e = 1'b1;
          checkOutput("out_data", 128'(out_data), 128'(e.data));
          checkOutput("out_flags_syn", 128'({out_single, out_double, out_syn}),
                      128'({e.single, e.dbl, e.syn}));
        end
      end
    end
    if (rst) begin
      sb.delete();
      in_flight  = 0;
      prev_stall = 1'b0;
    end else begin
      in_flight  = in_flight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      prev_snap  = cur_snap;
    end
    if (rst || cnt_clear) begin
      exp_single     = 0;
      exp_double     = 0;
      exp_sat_single = 0;
      exp_sat_double = 0;
    end else if (have_e) begin
      if (e.single) begin
        if (exp_single < 65535) exp_single++;
        if (exp_sat_single < 3) exp_sat_single++;
      end
      if (e.dbl) begin
        if (exp_double < 65535) exp_double++;
        if (exp_sat_double < 3) exp_sat_double++;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] rd;
    logic [CW:0]   enc;
    logic [CW:0]   w;
    int            b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cnt_clear = 1'b0;
    d0        = 64'h0123_4567_89AB_CDEF;
    enc       = encode(d0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_out_data", 128'(out_data), 128'(0));
    checkOutput("reset_flags_syn", 128'({out_single, out_double, out_syn}), 128'(0));

    // Clean word, first-transaction latency
    step();
    applyStimulus(enc, mk(d0, 1'b0, 1'b0, 0));
    checkLatency("clean_latency");
    drain();

    // Every single-bit flip, back to back
    for (int i = 0; i < CW + 1; i++) begin
      w    = enc;
      w[i] = ~w[i];
      applyStimulus(w, mk(d0, 1'b1, 1'b0, single_syn(i)));
    end
    drain();
    checkOutput("single_cnt_after_72", 128'(single_cnt), 128'(72));
    checkOutput("sat_single_after_72", 128'(sat_single_cnt), 128'(3));
    checkOutput("double_cnt_after_singles", 128'(double_cnt), 128'(0));

    // Double error: Hamming positions 3 and 6 hit data bits 0 and 2
    w    = enc;
    w[2] = ~w[2];
    w[5] = ~w[5];
    applyStimulus(w, mk(d0 ^ 64'h5, 1'b0, 1'b1, 5));
    drain();
    checkOutput("double_cnt_after_double", 128'(double_cnt), 128'(1));

    // Odd flip count whose syndrome (73) points beyond the code word
    w     = enc;
    w[0]  = ~w[0];
    w[7]  = ~w[7];
    w[63] = ~w[63];
    applyStimulus(w, mk(d0, 1'b0, 1'b1, 73));
    drain();
    checkOutput("double_cnt_out_of_range", 128'(double_cnt), 128'(2));

    // Backpressure: random out_ready over 10 back-to-back words
    ready_mode = 1;
    for (int n = 0; n < 10; n++) begin
      rd = {$urandom(), $urandom()};
      w  = encode(rd);
      if ((n % 3) == 1) begin
        b    = (n * 7) % (CW + 1);
        w[b] = ~w[b];
        applyStimulus(w, mk(rd, 1'b1, 1'b0, single_syn(b)));
      end else begin
        applyStimulus(w, mk(rd, 1'b0, 1'b0, 0));
      end
    end
    ready_mode = 0;
    drain();

    // Saturation with the narrow counters
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    checkOutput("clear_single_cnt", 128'(single_cnt), 128'(0));
    for (int i = 10; i < 15; i++) begin
      w    = enc;
      w[i] = ~w[i];
      applyStimulus(w, mk(d0, 1'b1, 1'b0, i + 1));
    end
    drain();
    checkOutput("single_cnt_after_5", 128'(single_cnt), 128'(5));
    checkOutput("sat_single_saturated", 128'(sat_single_cnt), 128'(3));

    // Clear coinciding with a single-error output handshake
    w     = enc;
    w[20] = ~w[20];
    applyStimulus(w, mk(d0, 1'b1, 1'b0, 21));
    step();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    checkOutput("clear_wins_single", 128'(single_cnt), 128'(0));
    checkOutput("clear_wins_sat_single", 128'(sat_single_cnt), 128'(0));
    drain();

    // Reset with two words in flight
    w     = enc;
    w[30] = ~w[30];
    applyStimulus(w, mk(d0, 1'b1, 1'b0, 31));
    drain();
    checkOutput("single_cnt_before_reset", 128'(single_cnt), 128'(1));
    ready_mode = 2;
    applyStimulus(enc, mk(d0, 1'b0, 1'b0, 0));
    applyStimulus(enc, mk(d0, 1'b0, 1'b0, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    checkOutput("midreset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("midreset_single_cnt", 128'(single_cnt), 128'(0));
    checkOutput("midreset_double_cnt", 128'(double_cnt), 128'(0));
    step();
    rd = 64'hDEAD_BEEF_0BAD_F00D;
    applyStimulus(encode(rd), mk(rd, 1'b0, 1'b0, 0));
    checkLatency("post_reset_latency");
    drain();

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
